// File: rtl/pwm_controller.sv
// 16-channel PWM / static-high output driver fed by the SPI configuration bytes.
// Live configuration is captured into shadow registers only at PWM period boundaries.
module pwm_controller #(
   parameter int PRESCALE = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   input  logic        cfg_valid,
   output logic [15:0] pwm_out,
   output logic        period_start,
   output logic        update_pending
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t        state_reg, state_next;
   logic [PW-1:0] presc_reg, presc_next;
   logic [7:0]    count_reg, count_next;
   logic [15:0]   en_sh_reg, en_sh_next;
   logic [15:0]   sel_sh_reg, sel_sh_next;
   logic [7:0]    duty_sh_reg, duty_sh_next;
   logic          pending_reg, pending_next;
   logic          start_reg, start_next;
   logic [15:0]   pwm_reg, pwm_next;

   logic [15:0]   live_en, live_sel, loaded_en;
   logic          tick, boundary, level, load_now;

   assign live_en  = {en_reg_out_15_8, en_reg_out_7_0};
   assign live_sel = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   assign tick     = (state_reg == RUN) && (presc_reg == PRESC_LAST);
   assign boundary = tick && (count_reg == 8'hFF);
   // Full-scale duty must stay high through counter value 255 as well.
   assign level    = (duty_sh_reg == 8'hFF) || (count_reg < duty_sh_reg);

   // A cfg_valid on the boundary cycle itself is folded straight into the load.
   assign load_now  = boundary && (pending_reg || cfg_valid);
   assign loaded_en = load_now ? live_en : en_sh_reg;

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_out
         assign pwm_next[gi] = en_sh_reg[gi] & (sel_sh_reg[gi] ? level : 1'b1);
      end
   endgenerate

   always_comb begin
      state_next   = state_reg;
      presc_next   = presc_reg;
      count_next   = count_reg;
      en_sh_next   = en_sh_reg;
      sel_sh_next  = sel_sh_reg;
      duty_sh_next = duty_sh_reg;
      pending_next = pending_reg;
      start_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            presc_next = '0;
            count_next = '0;
            if (cfg_valid) begin
               en_sh_next   = live_en;
               sel_sh_next  = live_sel;
               duty_sh_next = pwm_duty_cycle;
               if (live_en != 16'h0000) begin
                  state_next = RUN;
                  start_next = 1'b1;
               end
            end
         end

         RUN: begin
            presc_next = tick ? '0 : presc_reg + PW'(1);
            count_next = tick ? count_reg + 8'd1 : count_reg;
            if (boundary) begin
               pending_next = 1'b0;
               if (load_now) begin
                  en_sh_next   = live_en;
                  sel_sh_next  = live_sel;
                  duty_sh_next = pwm_duty_cycle;
               end
               if (loaded_en == 16'h0000) begin
                  state_next = IDLE;
                  presc_next = '0;
                  count_next = '0;
               end else begin
                  start_next = 1'b1;
               end
            end else if (cfg_valid) begin
               pending_next = 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         presc_reg   <= '0;
         count_reg   <= '0;
         en_sh_reg   <= '0;
         sel_sh_reg  <= '0;
         duty_sh_reg <= '0;
         pending_reg <= 1'b0;
         start_reg   <= 1'b0;
         pwm_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         presc_reg   <= presc_next;
         count_reg   <= count_next;
         en_sh_reg   <= en_sh_next;
         sel_sh_reg  <= sel_sh_next;
         duty_sh_reg <= duty_sh_next;
         pending_reg <= pending_next;
         start_reg   <= start_next;
         pwm_reg     <= pwm_next;
      end
   end

   assign pwm_out        = pwm_reg;
   assign period_start   = start_reg;
   assign update_pending = pending_reg;

endmodule

// File: tb/tb_pwm_controller.sv
// Bench for pwm_controller: period-position reference model checked every cycle,
// directed period measurements with literal expectations, then random traffic.
module tb_pwm_controller;
   localparam int P      = 12;
   localparam int PERIOD = 256 * P;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_valid = 1'b0;
   logic [15:0] live_en = '0;
   logic [15:0] live_sel = '0;
   logic [7:0]  duty = '0;
   logic [15:0] pwm_out;
   logic        period_start;
   logic        update_pending;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   pwm_controller #(.PRESCALE(P)) dut (
      .clk            (clk),
      .rst            (rst),
      .en_reg_out_7_0 (live_en[7:0]),
      .en_reg_out_15_8(live_en[15:8]),
      .en_reg_pwm_7_0 (live_sel[7:0]),
      .en_reg_pwm_15_8(live_sel[15:8]),
      .pwm_duty_cycle (duty),
      .cfg_valid      (cfg_valid),
      .pwm_out        (pwm_out),
      .period_start   (period_start),
      .update_pending (update_pending)
   );

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %0d (0x%0h), expected %0d (0x%0h)", name, $time, act, act, exp, exp);
      end
   endtask

   // Reference model: tracks run position within the period instead of counters.
   logic        m_valid = 1'b0;
   logic        m_run = 1'b0;
   int          m_pos = 0;
   logic [15:0] m_en = '0, m_sel = '0;
   logic [7:0]  m_duty = '0;
   logic        m_pend = 1'b0;
   logic [15:0] exp_pwm = '0;
   logic        exp_ps = 1'b0;

   initial begin : compare_proc
      int  tick_no;
      logic lvl;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_valid = 1'b1;
            m_run = 1'b0; m_pos = 0; m_en = '0; m_sel = '0; m_duty = '0;
            m_pend = 1'b0; exp_pwm = '0; exp_ps = 1'b0;
         end else begin
            if (m_run) begin
               tick_no = m_pos / P;
               lvl = (m_duty == 8'hFF) || (tick_no < int'(m_duty));
               exp_pwm = m_en & (lvl ? 16'hFFFF : ~m_sel);
            end else begin
               exp_pwm = '0;
            end
            exp_ps = 1'b0;
            if (!m_run) begin
               if (cfg_valid) begin
                  m_en = live_en; m_sel = live_sel; m_duty = duty;
                  if (live_en != 0) begin
                     m_run = 1'b1; m_pos = 0; exp_ps = 1'b1;
                  end
               end
            end else if (m_pos == PERIOD - 1) begin
               if (m_pend || cfg_valid) begin
                  m_en = live_en; m_sel = live_sel; m_duty = duty;
               end
               m_pend = 1'b0;
               m_pos = 0;
               if (m_en == 0) m_run = 1'b0;
               else exp_ps = 1'b1;
            end else begin
               if (cfg_valid) m_pend = 1'b1;
               m_pos++;
            end
         end
         #1;
         if (m_valid) begin
            check("model_pwm_out", int'(pwm_out), int'(exp_pwm));
            check("model_period_start", int'(period_start), int'(exp_ps));
            check("model_update_pending", int'(update_pending), int'(m_pend));
         end
      end
   end

   task automatic set_live(input logic [15:0] en, input logic [15:0] sel, input logic [7:0] d);
      live_en = en; live_sel = sel; duty = d;
   endtask

   // Runs n cycles from a negedge; cfg_valid is high during cycle index pulse_at.
   task automatic measure(input string tag, input int n, input int pulse_at,
                          output int hi, output int ps, output int pend);
      hi = 0; ps = 0; pend = 0;
      for (int i = 0; i < n; i++) begin
         cfg_valid = (i == pulse_at);
         @(negedge clk);
         hi   += int'(pwm_out[0]);
         ps   += int'(period_start);
         pend += int'(update_pending);
      end
      cfg_valid = 1'b0;
      $display("txn %-10s cycles=%0d pulse_at=%0d high=%0d period_starts=%0d pending_cycles=%0d",
               tag, n, pulse_at, hi, ps, pend);
   endtask

   initial begin : stim_proc
      int hi, ps, pend;
      logic [7:0] picks [6];
      picks[0] = 8'h00; picks[1] = 8'h01; picks[2] = 8'h80;
      picks[3] = 8'hFE; picks[4] = 8'hFF; picks[5] = 8'h33;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_pwm_out", int'(pwm_out), 0);
      check("reset_period_start", int'(period_start), 0);
      check("reset_update_pending", int'(update_pending), 0);

      // Start from IDLE: single static-high output.
      set_live(16'h0001, 16'h0000, 8'h00);
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      $display("txn start     en=0001 sel=0000 duty=00");
      check("start_period_start", int'(period_start), 1);
      check("start_pwm_out", int'(pwm_out), 0);
      check("start_pending", int'(update_pending), 0);

      set_live(16'hFFFF, 16'hFFFF, 8'h80);
      measure("static", PERIOD, 0, hi, ps, pend);
      check("static_high", hi, PERIOD);
      check("static_ps", ps, 1);
      check("static_pending", pend, PERIOD - 1);

      set_live(16'hFFFF, 16'hFFFF, 8'hFF);
      measure("duty80", PERIOD, 0, hi, ps, pend);
      check("duty80_high", hi, 128 * P);
      check("duty80_ps", ps, 1);

      set_live(16'hFFFF, 16'hFFFF, 8'h00);
      measure("dutyFF", PERIOD, 0, hi, ps, pend);
      check("dutyFF_high", hi, PERIOD);

      set_live(16'hFFFF, 16'hFFFF, 8'h01);
      measure("duty00", PERIOD, 0, hi, ps, pend);
      check("duty00_high", hi, 0);

      set_live(16'hFFFF, 16'hFFFF, 8'h40);
      measure("duty01", PERIOD, 0, hi, ps, pend);
      check("duty01_high", hi, P);

      // Mid-period change 0x40 -> 0xC0.
      set_live(16'hFFFF, 16'hFFFF, 8'hC0);
      measure("duty40", PERIOD, 100, hi, ps, pend);
      check("duty40_high", hi, 64 * P);
      check("duty40_pending", pend, PERIOD - 1 - 100);

      // cfg_valid exactly on the boundary cycle.
      set_live(16'hFFFF, 16'hFFFF, 8'h20);
      measure("dutyC0", PERIOD, PERIOD - 1, hi, ps, pend);
      check("dutyC0_high", hi, 192 * P);
      check("boundary_cfg_pending", pend, 0);
      check("dutyC0_ps", ps, 1);

      // Boundary write of all-zero enables drops to IDLE.
      set_live(16'h0000, 16'hFFFF, 8'h20);
      measure("duty20", PERIOD, PERIOD - 1, hi, ps, pend);
      check("duty20_high", hi, 32 * P);
      check("to_idle_ps", ps, 0);
      check("to_idle_pending", pend, 0);

      measure("idle", PERIOD, -1, hi, ps, pend);
      check("idle_high", hi, 0);
      check("idle_ps", ps, 0);

      // Reset mid-period with a change pending.
      set_live(16'hFFFF, 16'h0000, 8'h00);
      measure("restart", 600, 0, hi, ps, pend);
      check("restart_ps", ps, 1);
      check("restart_high", hi, 599);
      set_live(16'h00FF, 16'hFFFF, 8'h55);
      measure("pend", 10, 0, hi, ps, pend);
      check("pend_cycles", pend, 10);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      $display("txn reset     mid-period");
      check("midrst_pwm_out", int'(pwm_out), 0);
      check("midrst_pending", int'(update_pending), 0);
      check("midrst_ps", int'(period_start), 0);
      measure("after_rst", 3500, -1, hi, ps, pend);
      check("after_rst_high", hi, 0);
      check("after_rst_ps", ps, 0);

      // Random traffic: live inputs churn every cycle, occasional writes and resets.
      for (int i = 0; i < 24000; i++) begin
         live_en  = 16'($urandom);
         live_sel = 16'($urandom);
         duty     = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 5)] : 8'($urandom);
         cfg_valid = (i == 0) || ($urandom_range(0, 1499) == 0);
         if (cfg_valid && $urandom_range(0, 7) == 0) live_en = 16'h0000;
         rst = ($urandom_range(0, 9999) == 0);
         if (cfg_valid || rst)
            $display("txn random    cycle=%0d cfg=%0b rst=%0b en=%04h sel=%04h duty=%02h",
                     i, cfg_valid, rst, live_en, live_sel, duty);
         @(negedge clk);
      end
      cfg_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
